wb_master_bridge: RTL and testbench
===================================

# wb_master_bridge

Converts the core's native valid/ready request/response channels into single Wishbone classic master cycles. It sits directly upstream of `wb_sram` or any other slave with the same port set, and drives that slave's `wb_*` inputs. One transaction is outstanding at a time. A cycle counter aborts transfers that the slave never acknowledges.

## Interface
- `addr_width`, 32, address width of request and Wishbone bus
- `data_width`, 32, data width
- `strobe_width`, `data_width/8`, byte-select width
- `timeout`, 255, maximum cycles `wb_stb` may stay high without `wb_ack`; 0 disables the check

Ports:
- `clock`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  bridge accepts request
- `req_addr`  in  `addr_width`  byte address
- `req_wdata`  in  `data_width`  write data
- `req_strobe`  in  `strobe_width`  byte enables
- `req_we`  in  1  1 = write, 0 = read
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  `data_width`  read data; 0 for writes and errors
- `resp_err`  out  1  transfer timed out
- `wb_adr`  out  `addr_width`  Wishbone address
- `wb_datwr`  out  `data_width`  Wishbone write data
- `wb_datrd`  in  `data_width`  Wishbone read data
- `wb_we`  out  1  Wishbone write enable
- `wb_sel`  out  `strobe_width`  Wishbone byte select
- `wb_stb`  out  1  Wishbone strobe
- `wb_cyc`  out  1  Wishbone cycle
- `wb_ack`  in  1  Wishbone acknowledge

## Operation
- States are IDLE, BUS and RESP.
- **IDLE:** `req_ready`=1, combinational from the state.
  - When `req_valid`&&`req_ready` at an edge: register `req_addr`, `req_wdata`, `req_strobe` and `req_we` into `wb_adr`, `wb_datwr`, `wb_sel` and `wb_we`.
  - Set `wb_cyc`=`wb_stb`=1, clear the timeout counter, go to BUS.
- **BUS:** `req_ready`=0. All `wb_*` outputs are held stable.
  - If `wb_ack`=1 at an edge:
    - Set `wb_cyc`=`wb_stb`=0.
    - `resp_rdata` <= `wb_datrd` when `wb_we`=0, else 0.
    - `resp_err` <= 0, `resp_valid` <= 1, go to RESP.
  - Else if `timeout`!=0 and the counter equals `timeout`-1:
    - Set `wb_cyc`=`wb_stb`=0, `resp_rdata` <= 0, `resp_err` <= 1, `resp_valid` <= 1, go to RESP.
  - Else increment the counter. Its width is `$clog2(timeout+1)`, minimum 1, and it never wraps.
- **RESP:** `resp_valid`, `resp_rdata` and `resp_err` are held stable until `resp_valid`&&`resp_ready` at an edge. Then `resp_valid` <= 0 and go to IDLE.
- `wb_ack` is ignored in IDLE and RESP. A late ack after a timeout has no effect.
- `wb_cyc` and `wb_stb` are always equal: no pipelined or burst cycles.
- **Reset values:**
  - State IDLE, so `req_ready`=1 in the first cycle after reset.
  - `wb_cyc`, `wb_stb`, `wb_we` = 0; `wb_adr`, `wb_datwr`, `wb_sel` = 0.
  - `resp_valid`, `resp_err` = 0; `resp_rdata` = 0; counter = 0.
- **Reset mid-operation** (BUS or RESP): the next edge forces the reset values. The in-flight transaction is dropped and produces no response.

## Timing
- The request handshake at edge k gives `wb_stb`=1 after k.
- A slave acking one cycle after strobe raises `wb_ack` after k+1. The bridge samples it at k+2, so `wb_stb`=0 and `resp_valid`=1 after k+2.
- With `resp_ready`=1, the response is consumed at k+3 and `req_ready`=1 after k+3.
- Peak throughput is one transaction per 4 cycles with a single-cycle-ack slave.
- `wb_stb` falls in the cycle after ack is seen, so a slave's registered ack deasserts with no repeated access.
- Timeout: `wb_stb` is high for exactly `timeout` cycles, then `resp_err`=1.
- No combinational path exists from any `wb_*` input to any output. `req_ready` depends only on state.

## Test plan
- **Read:** slave preloaded with word 0x10 = 0xDEADBEEF; read request at 0x10 -> `wb_adr`=0x10, `wb_we`=0, `wb_stb` high 2 cycles, `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` exactly 2 cycles after accept.
- **Byte-masked write:** 0x11223344 to 0x20 with strobe 0b0011 over a word holding 0xAAAAAAAA, then a read of 0x20 -> first `resp_rdata`=0, second 0xAAAA3344.
- **Response backpressure:** `resp_ready`=0 for 5 cycles with `req_valid`=1 -> `resp_valid`, `resp_rdata` stable; `req_ready`=0; `wb_stb`=0 throughout; the next transaction starts only after release.
- **Timeout:** `timeout`=8, slave ack tied 0 -> `wb_stb` high exactly 8 cycles, `resp_err`=1, `resp_rdata`=0. A forced ack afterwards is ignored.
- **Back-to-back:** 4 reads with `req_valid` held high and `resp_ready`=1 -> responses in order, 4 cycles apart.
- **Reset mid-BUS:** reset asserted 1 cycle after accept -> next cycle `wb_cyc`=`wb_stb`=0, `resp_valid`=0, `req_ready`=1; no response emitted.

Source files
------------

// File: rtl/wb_master_bridge_if.sv
// Bundle of the native request/response channels and the Wishbone classic bus.
// The master modport is the bridge's view; the slave modport is the surrounding environment's view.
interface wb_master_bridge_if #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [addr_width-1:0]   req_addr;
  logic [data_width-1:0]   req_wdata;
  logic [strobe_width-1:0] req_strobe;
  logic                    req_we;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [data_width-1:0]   resp_rdata;
  logic                    resp_err;

  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic [strobe_width-1:0] wb_sel;
  logic                    wb_stb;
  logic                    wb_cyc;
  logic                    wb_ack;

  modport master (
    input  req_valid, req_addr, req_wdata, req_strobe, req_we,
    input  resp_ready, wb_datrd, wb_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_strobe, req_we,
    output resp_ready, wb_datrd, wb_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Turns one valid/ready request into a single Wishbone classic cycle and returns one response.
// A bounded cycle counter aborts transfers the slave never acknowledges.
module wb_master_bridge #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8,
  parameter int timeout      = 255
) (
  input logic             clock,
  input logic             reset,
  wb_master_bridge_if.master bus
);

  localparam int cnt_width = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'((timeout > 0) ? timeout - 1 : 0);
  localparam logic [cnt_width-1:0] cnt_max  = '1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    ack_hit;
  logic                    time_hit;
  logic                    resp_fire;
  logic [cnt_width-1:0]    count;

  logic [addr_width-1:0]   adr_q;
  logic [data_width-1:0]   datwr_q;
  logic [strobe_width-1:0] sel_q;
  logic                    we_q;
  logic                    stb_q;
  logic                    resp_valid_q;
  logic [data_width-1:0]   resp_rdata_q;
  logic                    resp_err_q;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_hit    = 1'b0;
    time_hit   = 1'b0;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (bus.wb_ack) begin
          ack_hit    = 1'b1;
          state_next = RESP;
        end else if ((timeout != 0) && (count == cnt_last)) begin
          time_hit   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output except req_ready is a flop, so nothing on the Wishbone side reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      adr_q        <= '0;
      datwr_q      <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      stb_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        adr_q   <= bus.req_addr;
        datwr_q <= bus.req_wdata;
        sel_q   <= bus.req_strobe;
        we_q    <= bus.req_we;
        stb_q   <= 1'b1;
        count   <= '0;
      end else if (ack_hit) begin
        stb_q        <= 1'b0;
        resp_rdata_q <= we_q ? '0 : bus.wb_datrd;
        resp_err_q   <= 1'b0;
        resp_valid_q <= 1'b1;
      end else if (time_hit) begin
        stb_q        <= 1'b0;
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b1;
        resp_valid_q <= 1'b1;
      end else if ((state == BUS) && (count != cnt_max)) begin
        count <= count + 1'b1;
      end
      if (resp_fire) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.wb_adr     = adr_q;
  assign bus.wb_datwr   = datwr_q;
  assign bus.wb_sel     = sel_q;
  assign bus.wb_we      = we_q;
  assign bus.wb_stb     = stb_q;
  assign bus.wb_cyc     = stb_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge against a small single-cycle-ack Wishbone memory model.
module tb_wb_master_bridge;

  logic clock = 1'b0;
  logic reset;
  logic slave_reset;
  logic slave_en;
  logic force_ack;
  logic slave_ack;
  logic [31:0] slave_rdata;
  logic [31:0] mem [16];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int stb_cycles;
  int resp_cycle;
  int last_resp_cycle;
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  always #5 clock = ~clock;

  wb_master_bridge_if #(.addr_width(32), .data_width(32), .strobe_width(4)) bus ();

  wb_master_bridge #(
    .addr_width(32),
    .data_width(32),
    .strobe_width(4),
    .timeout(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  assign bus.wb_ack   = slave_ack | force_ack;
  assign bus.wb_datrd = slave_rdata;

  // Memory slave: registered ack one cycle after strobe, dropped once seen so no access repeats.
  always_ff @(posedge clock) begin
    if (slave_reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h11111111;
      mem[4]      <= 32'hDEADBEEF;
      mem[8]      <= 32'hAAAAAAAA;
      slave_ack   <= 1'b0;
      slave_rdata <= '0;
    end else begin
      slave_ack <= bus.wb_cyc && bus.wb_stb && !slave_ack && slave_en;
      if (bus.wb_cyc && bus.wb_stb && !slave_ack && slave_en) begin
        slave_rdata <= mem[bus.wb_adr[5:2]];
        if (bus.wb_we) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.wb_sel[b]) mem[bus.wb_adr[5:2]][8*b +: 8] <= bus.wb_datwr[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strobe, input logic we);
    bus.req_valid  = valid;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_strobe = strobe;
    bus.req_we     = we;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset          = 1'b1;
    slave_reset    = 1'b1;
    slave_en       = 1'b1;
    force_ack      = 1'b0;
    bus.resp_ready = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step();
    step();
    reset       = 1'b0;
    slave_reset = 1'b0;

    check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    check_output("rst_stb", 32'(bus.wb_stb), 32'd0);
    check_output("rst_we", 32'(bus.wb_we), 32'd0);
    check_output("rst_adr", bus.wb_adr, 32'h0);
    check_output("rst_sel", 32'(bus.wb_sel), 32'h0);
    check_output("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check_output("rst_resp_rdata", bus.resp_rdata, 32'h0);

    // Single read of 0x10.
    apply_stimulus(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_output("rd_stb_k", 32'(bus.wb_stb), 32'd1);
    check_output("rd_cyc_k", 32'(bus.wb_cyc), 32'd1);
    check_output("rd_adr", bus.wb_adr, 32'h10);
    check_output("rd_we", 32'(bus.wb_we), 32'd0);
    check_output("rd_req_ready_bus", 32'(bus.req_ready), 32'd0);
    step();
    check_output("rd_stb_k1", 32'(bus.wb_stb), 32'd1);
    check_output("rd_valid_k1", 32'(bus.resp_valid), 32'd0);
    step();
    check_output("rd_stb_k2", 32'(bus.wb_stb), 32'd0);
    check_output("rd_valid_k2", 32'(bus.resp_valid), 32'd1);
    check_output("rd_rdata", bus.resp_rdata, 32'hDEADBEEF);
    check_output("rd_err", 32'(bus.resp_err), 32'd0);
    step();
    check_output("rd_valid_k3", 32'(bus.resp_valid), 32'd0);
    check_output("rd_req_ready_k3", 32'(bus.req_ready), 32'd1);

    // Byte-masked write then read-back.
    apply_stimulus(1'b1, 32'h20, 32'h11223344, 4'b0011, 1'b1);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_output("wr_we", 32'(bus.wb_we), 32'd1);
    check_output("wr_sel", 32'(bus.wb_sel), 32'h3);
    check_output("wr_datwr", bus.wb_datwr, 32'h11223344);
    check_output("wr_adr", bus.wb_adr, 32'h20);
    step();
    step();
    check_output("wr_valid", 32'(bus.resp_valid), 32'd1);
    check_output("wr_rdata", bus.resp_rdata, 32'h0);
    step();
    apply_stimulus(1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step();
    step();
    check_output("wr_rb_valid", 32'(bus.resp_valid), 32'd1);
    check_output("wr_rb_rdata", bus.resp_rdata, 32'hAAAA3344);
    step();

    // Response backpressure with a pending request behind it.
    bus.resp_ready = 1'b0;
    apply_stimulus(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    step();
    step();
    step();
    check_output("bp_valid_first", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("bp_valid_%0d", i), 32'(bus.resp_valid), 32'd1);
      check_output($sformatf("bp_rdata_%0d", i), bus.resp_rdata, 32'hDEADBEEF);
      check_output($sformatf("bp_req_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      check_output($sformatf("bp_stb_%0d", i), 32'(bus.wb_stb), 32'd0);
    end
    bus.resp_ready = 1'b1;
    apply_stimulus(1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
    step();
    check_output("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    check_output("bp_release_stb", 32'(bus.wb_stb), 32'd0);
    check_output("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_output("bp_next_stb", 32'(bus.wb_stb), 32'd1);
    check_output("bp_next_adr", bus.wb_adr, 32'h20);
    step();
    step();
    check_output("bp_next_rdata", bus.resp_rdata, 32'hAAAA3344);
    step();

    // Timeout with a silent slave, then a stray ack that must be ignored.
    slave_en = 1'b0;
    apply_stimulus(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    stb_cycles = 0;
    while (bus.wb_stb && stb_cycles < 20) begin
      stb_cycles++;
      step();
    end
    check_output("to_stb_cycles", 32'(stb_cycles), 32'd8);
    check_output("to_valid", 32'(bus.resp_valid), 32'd1);
    check_output("to_err", 32'(bus.resp_err), 32'd1);
    check_output("to_rdata", bus.resp_rdata, 32'h0);
    bus.resp_ready = 1'b0;
    force_ack      = 1'b1;
    step();
    check_output("to_late_ack_err", 32'(bus.resp_err), 32'd1);
    check_output("to_late_ack_valid", 32'(bus.resp_valid), 32'd1);
    check_output("to_late_ack_rdata", bus.resp_rdata, 32'h0);
    bus.resp_ready = 1'b1;
    step();
    step();
    check_output("to_idle_ack_stb", 32'(bus.wb_stb), 32'd0);
    check_output("to_idle_ack_valid", 32'(bus.resp_valid), 32'd0);
    check_output("to_idle_ack_ready", 32'(bus.req_ready), 32'd1);
    force_ack = 1'b0;
    slave_en  = 1'b1;
    step();

    // Back-to-back reads with req_valid held high.
    b2b_addr[0] = 32'h10; b2b_data[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h20; b2b_data[1] = 32'hAAAA3344;
    b2b_addr[2] = 32'h30; b2b_data[2] = 32'hCCCCCCCC;
    b2b_addr[3] = 32'h34; b2b_data[3] = 32'hDDDDDDDD;
    last_resp_cycle = -1;
    for (int t = 0; t < 4; t++) begin
      apply_stimulus(1'b1, b2b_addr[t], 32'h0, 4'hF, 1'b0);
      step();
      check_output($sformatf("b2b_adr_%0d", t), bus.wb_adr, b2b_addr[t]);
      step();
      step();
      resp_cycle = cycle;
      check_output($sformatf("b2b_valid_%0d", t), 32'(bus.resp_valid), 32'd1);
      check_output($sformatf("b2b_rdata_%0d", t), bus.resp_rdata, b2b_data[t]);
      if (t > 0) check_output($sformatf("b2b_spacing_%0d", t), 32'(resp_cycle - last_resp_cycle), 32'd4);
      last_resp_cycle = resp_cycle;
      step();
      check_output($sformatf("b2b_stb_gap_%0d", t), 32'(bus.wb_stb), 32'd0);
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step();

    // Reset one cycle after accept drops the transfer.
    apply_stimulus(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("mid_rst_cyc", 32'(bus.wb_cyc), 32'd0);
    check_output("mid_rst_stb", 32'(bus.wb_stb), 32'd0);
    check_output("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    check_output("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_output("mid_rst_adr", bus.wb_adr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("mid_rst_no_resp_%0d", i), 32'(bus.resp_valid), 32'd0);
      check_output($sformatf("mid_rst_no_stb_%0d", i), 32'(bus.wb_stb), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
